pa_tile_ctrl: RTL and testbench
===============================

// Module: pa_tile_ctrl
// PURPOSE
//  Parametrised tile sequencer for the processing-array (PA) matrix-multiply datapath: dst = lhs x rhs^T.
//  Per tile: loads TILE_ROWS weight rows plus per-row quant words into the ping-pong weight buffer, then
//  streams lhs data in groups of LANES rows and drives PA enable/clear and the address counters.
//  Drains results per group, then repeats for each tile until rhs_rows is covered. Sits between DMA and PA array.
// PARAMETERS
//  TILE_ROWS  16  rhs rows per tile (power of 2, 4..64)
//  LANES      4   elements per data/weight beat = lhs rows per group (power of 2)
//  DIM_W      32  width of dimension inputs and address outputs
//  QWORDS     3   extra words per weight row (bias, dst_multi, dst_shift)
//  PIPE_LAT   2   PA pipeline depth; cycles from last pa_en to results valid
// PORTS
//  clk            in   1      clock
//  counter_rst_n  in   1      asynchronous, active-low reset
//  start          in   1      one-cycle job start; sampled only in IDLE
//  abort          in   1      synchronous abort; valid in any state
//  rhs_rows       in   DIM_W  rhs (weight) row count; latched at start
//  rhs_cols       in   DIM_W  shared inner dimension; multiple of LANES
//  lhs_rows       in   DIM_W  lhs row count; multiple of LANES
//  wt_vld/wt_rdy  in/out 1    weight stream handshake (block is sink)
//  dat_vld/dat_rdy in/out 1   data stream handshake (block is sink)
//  res_vld/res_rdy out/in 1   result stream handshake (block is source)
//  wt_addr        out  DIM_W  word index of the next expected weight/quant word
//  dat_addr       out  DIM_W  word index of the next expected data word
//  res_addr       out  DIM_W  word index of the current result word
//  buf_row        out  $clog2(TILE_ROWS) weight-buffer row being written
//  buf_q          out  1      current weight word is a quant word; buf_qsel (2b) selects which
//  pa_en          out  1      PA accumulate enable (1 cycle after each data transfer)
//  pa_clr         out  1      one-cycle accumulator clear at each group start
//  pp_sel         out  1      ping-pong half used by PA; toggles when a tile load completes
//  res_sel        out  $clog2(TILE_ROWS) PA result index being emitted
//  state          out  3      encoded FSM state; busy out 1; done out 1 (one-cycle pulse); err out 1 (sticky)
// BEHAVIOUR
//  Reset: all outputs 0, state=IDLE, counters 0, pp_sel=0, err=0. Transfers occur on vld&rdy only.
//  States: IDLE(0) LOAD(1) COMPUTE(2) DRAIN(3) WRITE(4).
//  IDLE: start -> latch dims; any dim==0 -> done pulse next cycle, stay IDLE; else LOAD. busy=1 outside IDLE.
//  LOAD: wt_rdy=1; per row accept rhs_cols/LANES weight words then QWORDS quant words (buf_q=1, buf_qsel 0..2).
//    wt_addr = row*(rhs_cols/LANES+QWORDS)+beat. After last word of last tile row: pp_sel toggles, -> COMPUTE.
//  COMPUTE: dat_rdy=1; pa_clr pulses on entry cycle; accept rhs_cols beats (LANES rows x rhs_cols/LANES);
//    dat_addr = grp*rhs_cols + beat. pa_en registered, latency 1 from transfer. Last beat -> DRAIN.
//  DRAIN: wait PIPE_LAT cycles after the last pa_en, then -> WRITE. No rdy asserted.
//  WRITE: res_vld=1; res_sel 0..TILE_ROWS-1; res_addr = tile*(lhs_rows/LANES)*TILE_ROWS+grp*TILE_ROWS+res_sel.
//    Last result accepted: more groups -> COMPUTE (grp+1); else more tiles -> LOAD (tile+1, grp=0); else done pulse, IDLE.
//  Stalls: vld low holds all counters/addresses; res_vld & !res_rdy holds res_addr/res_sel stable.
//  start while busy: ignored. abort: -> IDLE next cycle, counters cleared, no done pulse, pp_sel kept.
//  abort and last-transfer same cycle: abort wins. Counters are DIM_W wide; no wrap within a legal job.
//  rhs_cols not multiple of LANES or lhs_rows not multiple of LANES: err=1 at start, job not started.
// CONFIGURATION
//  PA_PARTIAL_TILE_EN defined: rhs_rows need not be a multiple of TILE_ROWS; last tile loads only the
//    remaining rows, unused buffer rows are not written, WRITE emits only the valid rows (res_sel < remaining).
//  Not defined: rhs_rows % TILE_ROWS != 0 -> err=1 at start, job not started.
// TESTING
//  rhs 16x8, lhs 4, always vld/rdy -> 16*(2+3)=80 wt beats, 8 data beats, 16 results, 1 done; pp_sel ends 1.
//  rhs 32x8, lhs 8 -> 2 tiles x 2 groups; res_addr 0..63 contiguous; pa_clr pulses exactly 4 times.
//  Random vld/res_rdy backpressure (50%) -> identical address sequences to the no-stall case; res_addr stable while stalled.
//  abort mid-COMPUTE at beat 3 -> IDLE next cycle, no done, busy=0; new start runs clean from wt_addr 0.
//  rhs_rows=20: without PA_PARTIAL_TILE_EN err=1, no transfers; with it 2nd tile loads 4 rows, emits 4 results.
//  rhs_cols=0 start -> done pulse 1 cycle later, no transfers; start during busy -> no effect.

Source files
------------

// File: rtl/pa_tile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pa_tile_ctrl_if
//  Description : Stream handshakes and address/select outputs between the
//                PA tile sequencer and its DMA / PA-array neighbours.
//                  wt_vld/wt_rdy   weight stream (sequencer is the sink)
//                  wt_addr, buf_row, buf_q, buf_qsel  weight word position
//                  dat_vld/dat_rdy data stream (sequencer is the sink)
//                  dat_addr        data word position
//                  res_vld/res_rdy result stream (sequencer is the source)
//                  res_addr, res_sel  result word position / PA result index
//                Modport master : the sequencer side.
//                Modport slave  : the DMA / PA side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pa_tile_ctrl_if #(
    parameter int DIM_W     = 32,
    parameter int TILE_ROWS = 16
);
    localparam int c_ROW_W = $clog2(TILE_ROWS);

    logic               wt_vld;
    logic               wt_rdy;
    logic [DIM_W-1:0]   wt_addr;
    logic [c_ROW_W-1:0] buf_row;
    logic               buf_q;
    logic [1:0]         buf_qsel;

    logic               dat_vld;
    logic               dat_rdy;
    logic [DIM_W-1:0]   dat_addr;

    logic               res_vld;
    logic               res_rdy;
    logic [DIM_W-1:0]   res_addr;
    logic [c_ROW_W-1:0] res_sel;

    modport master (
        input  wt_vld, dat_vld, res_rdy,
        output wt_rdy, wt_addr, buf_row, buf_q, buf_qsel,
        output dat_rdy, dat_addr,
        output res_vld, res_addr, res_sel
    );

    modport slave (
        output wt_vld, dat_vld, res_rdy,
        input  wt_rdy, wt_addr, buf_row, buf_q, buf_qsel,
        input  dat_rdy, dat_addr,
        input  res_vld, res_addr, res_sel
    );
endinterface
`default_nettype wire

// File: rtl/pa_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pa_tile_ctrl
//  Description : Tile sequencer for the processing-array matrix multiply
//                dst = lhs x rhs^T. Per tile it loads TILE_ROWS weight rows
//                (rhs_cols/LANES weight words + QWORDS quant words each) into
//                the ping-pong weight buffer, streams lhs data in groups of
//                LANES rows, waits for the PA pipeline, then emits one result
//                per tile row for each group. Repeats until rhs_rows covered.
//  Ports       : clk, counter_rst_n (async, active-low)
//                start, abort, rhs_rows, rhs_cols, lhs_rows   job control
//                bus (pa_tile_ctrl_if.master)                 streams/addresses
//                pa_en, pa_clr, pp_sel                        PA control
//                state, busy, done, err                       status
//  Options     : PA_PARTIAL_TILE_EN - when defined, rhs_rows need not be a
//                multiple of TILE_ROWS; the last tile loads and emits only the
//                remaining rows. When undefined such a job raises err.
//  Limits      : QWORDS 1..4, PIPE_LAT >= 1, LANES and TILE_ROWS powers of 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module pa_tile_ctrl #(
    parameter int TILE_ROWS = 16,
    parameter int LANES     = 4,
    parameter int DIM_W     = 32,
    parameter int QWORDS    = 3,
    parameter int PIPE_LAT  = 2
) (
    input  wire logic             clk,
    input  wire logic             counter_rst_n,
    input  wire logic             start,
    input  wire logic             abort,
    input  wire logic [DIM_W-1:0] rhs_rows,
    input  wire logic [DIM_W-1:0] rhs_cols,
    input  wire logic [DIM_W-1:0] lhs_rows,
    pa_tile_ctrl_if.master        bus,
    output logic                  pa_en,
    output logic                  pa_clr,
    output logic                  pp_sel,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int                 c_ROW_W     = $clog2(TILE_ROWS);
    localparam int                 c_TILE_SH   = $clog2(TILE_ROWS);
    localparam int                 c_LANE_SH   = $clog2(LANES);
    localparam int                 c_DRN_W     = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DIM_W-1:0]   c_ONE       = DIM_W'(1);
    localparam logic [DIM_W-1:0]   c_TILE_ROWS = DIM_W'(TILE_ROWS);
    localparam logic [DIM_W-1:0]   c_TILE_MASK = DIM_W'(TILE_ROWS - 1);
    localparam logic [DIM_W-1:0]   c_LANE_MASK = DIM_W'(LANES - 1);
    localparam logic [1:0]         c_QLAST     = 2'(QWORDS - 1);
    localparam logic [c_DRN_W-1:0] c_DRN_LAST  = c_DRN_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    state_t             r_state;
    // job dimensions captured at start
    logic [DIM_W-1:0]   r_wpr;        // weight words per row
    logic [DIM_W-1:0]   r_cols;       // data beats per group
    logic [DIM_W-1:0]   r_ngrp;
    logic [DIM_W-1:0]   r_ntile;
`ifdef PA_PARTIAL_TILE_EN
    logic [DIM_W-1:0]   r_last_rows;  // rows in the final tile (1..TILE_ROWS)
`endif
    // progress counters
    logic [DIM_W-1:0]   r_tile;
    logic [DIM_W-1:0]   r_grp;
    logic [c_ROW_W-1:0] r_row;
    logic [DIM_W-1:0]   r_wbeat;
    logic               r_q;
    logic [1:0]         r_qsel;
    logic [DIM_W-1:0]   r_dat_beat;
    logic [DIM_W-1:0]   r_wt_addr;
    logic [DIM_W-1:0]   r_dat_addr;
    logic [DIM_W-1:0]   r_res_base;   // res_addr of result 0 of the current group
    logic [c_ROW_W-1:0] r_res_sel;
    logic [c_DRN_W-1:0] r_drn;
    // registered outputs
    logic               r_pa_en;
    logic               r_pa_clr;
    logic               r_pp_sel;
    logic               r_done;
    logic               r_err;

    logic               w_wt_xfer;
    logic               w_dat_xfer;
    logic               w_res_xfer;
    logic [DIM_W-1:0]   w_cur_rows;
    logic               w_row_last;
    logic               w_res_last;
    logic               w_lane_bad;
    logic               w_tile_bad;
    logic               w_zero;

    assign w_wt_xfer  = bus.wt_vld  && (r_state == S_LOAD);
    assign w_dat_xfer = bus.dat_vld && (r_state == S_COMPUTE);
    assign w_res_xfer = bus.res_rdy && (r_state == S_WRITE);

`ifdef PA_PARTIAL_TILE_EN
    assign w_cur_rows = (r_tile == r_ntile - c_ONE) ? r_last_rows : c_TILE_ROWS;
    assign w_tile_bad = 1'b0;
`else
    assign w_cur_rows = c_TILE_ROWS;
    assign w_tile_bad = |(rhs_rows & c_TILE_MASK);
`endif

    assign w_row_last = (DIM_W'(r_row)     == w_cur_rows - c_ONE);
    assign w_res_last = (DIM_W'(r_res_sel) == w_cur_rows - c_ONE);
    assign w_lane_bad = (|(rhs_cols & c_LANE_MASK)) || (|(lhs_rows & c_LANE_MASK));
    assign w_zero     = (rhs_rows == '0) || (rhs_cols == '0) || (lhs_rows == '0);

    always_ff @(posedge clk or negedge counter_rst_n) begin
        if (!counter_rst_n) begin
            r_state     <= S_IDLE;
            r_wpr       <= '0;
            r_cols      <= '0;
            r_ngrp      <= '0;
            r_ntile     <= '0;
`ifdef PA_PARTIAL_TILE_EN
            r_last_rows <= '0;
`endif
            r_tile      <= '0;
            r_grp       <= '0;
            r_row       <= '0;
            r_wbeat     <= '0;
            r_q         <= 1'b0;
            r_qsel      <= 2'd0;
            r_dat_beat  <= '0;
            r_wt_addr   <= '0;
            r_dat_addr  <= '0;
            r_res_base  <= '0;
            r_res_sel   <= '0;
            r_drn       <= '0;
            r_pa_en     <= 1'b0;
            r_pa_clr    <= 1'b0;
            r_pp_sel    <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pa_en  <= 1'b0;
            r_pa_clr <= 1'b0;
            r_done   <= 1'b0;

            // Counters sit at zero whenever idle, so every job (including
            // one following an abort) starts from address 0.
            if (abort || r_state == S_IDLE) begin
                r_tile     <= '0;
                r_grp      <= '0;
                r_row      <= '0;
                r_wbeat    <= '0;
                r_q        <= 1'b0;
                r_qsel     <= 2'd0;
                r_dat_beat <= '0;
                r_wt_addr  <= '0;
                r_dat_addr <= '0;
                r_res_base <= '0;
                r_res_sel  <= '0;
                r_drn      <= '0;
            end

            if (abort) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_lane_bad || w_tile_bad) begin
                                r_err <= 1'b1;
                            end else if (w_zero) begin
                                r_done <= 1'b1;
                            end else begin
                                r_wpr   <= rhs_cols >> c_LANE_SH;
                                r_cols  <= rhs_cols;
                                r_ngrp  <= lhs_rows >> c_LANE_SH;
                                r_ntile <= (rhs_rows >> c_TILE_SH)
                                         + DIM_W'(|(rhs_rows & c_TILE_MASK));
`ifdef PA_PARTIAL_TILE_EN
                                r_last_rows <= (|(rhs_rows & c_TILE_MASK))
                                             ? (rhs_rows & c_TILE_MASK) : c_TILE_ROWS;
`endif
                                r_state <= S_LOAD;
                            end
                        end
                    end

                    S_LOAD: begin
                        if (w_wt_xfer) begin
                            r_wt_addr <= r_wt_addr + c_ONE;
                            if (!r_q) begin
                                if (r_wbeat == r_wpr - c_ONE) begin
                                    r_wbeat <= '0;
                                    r_q     <= 1'b1;
                                    r_qsel  <= 2'd0;
                                end else begin
                                    r_wbeat <= r_wbeat + c_ONE;
                                end
                            end else if (r_qsel != c_QLAST) begin
                                r_qsel <= r_qsel + 2'd1;
                            end else begin
                                r_q    <= 1'b0;
                                r_qsel <= 2'd0;
                                if (w_row_last) begin
                                    // Tile fully buffered: hand this half to the PA.
                                    r_row      <= '0;
                                    r_pp_sel   <= ~r_pp_sel;
                                    r_grp      <= '0;
                                    r_dat_beat <= '0;
                                    r_dat_addr <= '0;
                                    r_pa_clr   <= 1'b1;
                                    r_state    <= S_COMPUTE;
                                end else begin
                                    r_row <= r_row + c_ROW_W'(1);
                                end
                            end
                        end
                    end

                    S_COMPUTE: begin
                        if (w_dat_xfer) begin
                            r_pa_en    <= 1'b1;
                            r_dat_addr <= r_dat_addr + c_ONE;
                            if (r_dat_beat == r_cols - c_ONE) begin
                                r_dat_beat <= '0;
                                r_drn      <= '0;
                                r_state    <= S_DRAIN;
                            end else begin
                                r_dat_beat <= r_dat_beat + c_ONE;
                            end
                        end
                    end

                    S_DRAIN: begin
                        // The last pa_en is high during the first DRAIN cycle;
                        // results are valid PIPE_LAT cycles after it.
                        if (r_drn == c_DRN_LAST) begin
                            r_drn     <= '0;
                            r_res_sel <= '0;
                            r_state   <= S_WRITE;
                        end else begin
                            r_drn <= r_drn + c_DRN_W'(1);
                        end
                    end

                    S_WRITE: begin
                        if (w_res_xfer) begin
                            if (w_res_last) begin
                                r_res_sel  <= '0;
                                r_res_base <= r_res_base + c_TILE_ROWS;
                                if (r_grp != r_ngrp - c_ONE) begin
                                    r_grp    <= r_grp + c_ONE;
                                    r_pa_clr <= 1'b1;
                                    r_state  <= S_COMPUTE;
                                end else if (r_tile != r_ntile - c_ONE) begin
                                    r_tile  <= r_tile + c_ONE;
                                    r_grp   <= '0;
                                    r_state <= S_LOAD;
                                end else begin
                                    r_done  <= 1'b1;
                                    r_state <= S_IDLE;
                                end
                            end else begin
                                r_res_sel <= r_res_sel + c_ROW_W'(1);
                            end
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Handshake strobes are decoded straight from the state register.
    assign bus.wt_rdy   = (r_state == S_LOAD);
    assign bus.dat_rdy  = (r_state == S_COMPUTE);
    assign bus.res_vld  = (r_state == S_WRITE);
    assign bus.wt_addr  = r_wt_addr;
    assign bus.buf_row  = r_row;
    assign bus.buf_q    = r_q;
    assign bus.buf_qsel = r_qsel;
    assign bus.dat_addr = r_dat_addr;
    assign bus.res_addr = r_res_base + DIM_W'(r_res_sel);
    assign bus.res_sel  = r_res_sel;

    assign pa_en  = r_pa_en;
    assign pa_clr = r_pa_clr;
    assign pp_sel = r_pp_sel;
    assign state  = r_state;
    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pa_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pa_tile_ctrl
//  Description : Directed self-checking bench for pa_tile_ctrl (TILE_ROWS=16,
//                LANES=4, QWORDS=3, PIPE_LAT=2). Jobs are driven with and
//                without backpressure; per-transfer addresses and per-job
//                totals are compared with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_tile_ctrl;
    localparam int TR = 16;
    localparam int LN = 4;
    localparam int DW = 32;
    localparam int QW = 3;
    localparam int PL = 2;

    logic          clk = 1'b0;
    logic          counter_rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] rhs_rows = '0;
    logic [DW-1:0] rhs_cols = '0;
    logic [DW-1:0] lhs_rows = '0;
    logic          pa_en, pa_clr, pp_sel, busy, done, err;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    pa_tile_ctrl_if #(.DIM_W(DW), .TILE_ROWS(TR)) bus ();

    pa_tile_ctrl #(
        .TILE_ROWS(TR), .LANES(LN), .DIM_W(DW), .QWORDS(QW), .PIPE_LAT(PL)
    ) dut (
        .clk          (clk),
        .counter_rst_n(counter_rst_n),
        .start        (start),
        .abort        (abort),
        .rhs_rows     (rhs_rows),
        .rhs_cols     (rhs_cols),
        .lhs_rows     (lhs_rows),
        .bus          (bus),
        .pa_en        (pa_en),
        .pa_clr       (pa_clr),
        .pp_sel       (pp_sel),
        .state        (state),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one job from the negedge on which it is called. Inputs change on
    // negedges only; a transfer is recognised when vld & rdy hold at a negedge
    // and completes at the following posedge.
    task automatic run_job(input int rr, input int rc, input int lr,
                           input bit stall, input bit poke, input int abort_at,
                           input int exp_wt, input int exp_dat, input int exp_res,
                           input int exp_clr, input bit exp_pp);
        int            wpr, per_row, ngrp, rem, rit, p;
        int            wt_n, dat_n, res_n, clr_n, en_n, done_n, dat_tile;
        int            m_tile, m_grp, m_sel, cyc;
        bit            fin, prev_hold, pp0;
        logic [DW-1:0] prev_addr;
        logic [3:0]    prev_sel;
        wpr = rc / LN; per_row = wpr + QW; ngrp = lr / LN;
        wt_n = 0; dat_n = 0; res_n = 0; clr_n = 0; en_n = 0; done_n = 0; dat_tile = 0;
        m_tile = 0; m_grp = 0; m_sel = 0; cyc = 0; fin = 0; prev_hold = 0;
        prev_addr = '0; prev_sel = '0;

        rhs_rows = DW'(rr); rhs_cols = DW'(rc); lhs_rows = DW'(lr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < 20000) begin
            cyc++;
            if (pa_clr) clr_n++;
            if (pa_en)  en_n++;
            if (done) begin
                done_n++;
                fin = 1;
            end
            if (prev_hold) begin
                check_eq("res_addr_hold", bus.res_addr, prev_addr);
                check_eq("res_sel_hold",  bus.res_sel,  prev_sel);
            end
            bus.wt_vld  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dat_vld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.res_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke) begin
                start = (cyc == 5);
                if (cyc == 5) rhs_cols = '0;
            end
            if (abort_at >= 0 && state == 3'd2 && dat_n == abort_at) begin
                abort = 1'b1;
                bus.dat_vld = 1'b0;
                pp0 = pp_sel;
                @(negedge clk);
                abort = 1'b0;
                check_eq("abort_state", state, 3'd0);
                check_eq("abort_busy",  busy,  1'b0);
                check_eq("abort_done",  done,  1'b0);
                check_eq("abort_pp",    pp_sel, pp0);
                @(negedge clk);
                check_eq("abort_no_late_done", done, 1'b0);
                return;
            end
            if (bus.wt_vld && bus.wt_rdy) begin
                p = wt_n % per_row;
                check_eq("wt_addr",  bus.wt_addr, wt_n);
                check_eq("buf_row",  bus.buf_row, (wt_n / per_row) % TR);
                check_eq("buf_q",    bus.buf_q,   p >= wpr);
                if (p >= wpr) check_eq("buf_qsel", bus.buf_qsel, p - wpr);
                wt_n++;
            end
            if (bus.dat_vld && bus.dat_rdy) begin
                check_eq("dat_addr", bus.dat_addr, dat_tile);
                dat_tile++;
                dat_n++;
            end
            if (bus.res_vld && bus.res_rdy) begin
                rem = rr - m_tile * TR;
                rit = (rem < TR) ? rem : TR;
                check_eq("res_addr", bus.res_addr, m_tile * ngrp * TR + m_grp * TR + m_sel);
                check_eq("res_sel",  bus.res_sel,  m_sel);
                res_n++;
                m_sel++;
                if (m_sel == rit) begin
                    m_sel = 0;
                    m_grp++;
                    if (m_grp == ngrp) begin
                        m_grp = 0;
                        m_tile++;
                        dat_tile = 0;
                    end
                end
            end
            prev_hold = bus.res_vld && !bus.res_rdy;
            prev_addr = bus.res_addr;
            prev_sel  = bus.res_sel;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        if (!fin) check_eq("job_timeout", 0, 1);
        check_eq("wt_beats",   wt_n,  exp_wt);
        check_eq("dat_beats",  dat_n, exp_dat);
        check_eq("res_beats",  res_n, exp_res);
        check_eq("pa_en_cnt",  en_n,  exp_dat);
        check_eq("pa_clr_cnt", clr_n, exp_clr);
        check_eq("done_cnt",   done_n, 1);
        check_eq("end_state",  state, 3'd0);
        check_eq("end_busy",   busy,  1'b0);
        check_eq("end_pp_sel", pp_sel, exp_pp);
        @(negedge clk);
        check_eq("done_pulse_width", done, 1'b0);
    endtask

    initial begin
        int rdy_seen;
        bus.wt_vld = 1'b0; bus.dat_vld = 1'b0; bus.res_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_state",   state, 3'd0);
        check_eq("rst_busy",    busy, 1'b0);
        check_eq("rst_done",    done, 1'b0);
        check_eq("rst_err",     err, 1'b0);
        check_eq("rst_pp_sel",  pp_sel, 1'b0);
        check_eq("rst_pa_en",   pa_en, 1'b0);
        check_eq("rst_pa_clr",  pa_clr, 1'b0);
        check_eq("rst_wt_rdy",  bus.wt_rdy, 1'b0);
        check_eq("rst_dat_rdy", bus.dat_rdy, 1'b0);
        check_eq("rst_res_vld", bus.res_vld, 1'b0);
        check_eq("rst_wt_addr", bus.wt_addr, 0);
        check_eq("rst_res_addr", bus.res_addr, 0);
        counter_rst_n = 1'b1;
        @(negedge clk);

        // 16x8 weights, 4 lhs rows; also a start pulse while busy
        run_job(16, 8, 4, 1'b0, 1'b1, -1, 80, 8, 16, 1, 1'b1);
        // 2 tiles x 2 groups, no stalls then with random stalls
        run_job(32, 8, 8, 1'b0, 1'b0, -1, 160, 32, 64, 4, 1'b1);
        run_job(32, 8, 8, 1'b1, 1'b0, -1, 160, 32, 64, 4, 1'b1);
        // abort after 3 data beats (tile load already toggled pp_sel to 0)
        run_job(16, 8, 4, 1'b0, 1'b0, 3, 0, 0, 0, 0, 1'b0);
        run_job(16, 8, 4, 1'b1, 1'b0, -1, 80, 8, 16, 1, 1'b1);

        // zero dimension: done next cycle, no transfers
        rhs_rows = 16; rhs_cols = 0; lhs_rows = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("zero_done", done, 1'b1);
        check_eq("zero_busy", busy, 1'b0);
        @(negedge clk);
        check_eq("zero_done_clear", done, 1'b0);
        check_eq("zero_wt_rdy", bus.wt_rdy, 1'b0);
        check_eq("zero_pp_sel", pp_sel, 1'b1);

        // rhs_rows not a multiple of TILE_ROWS
        counter_rst_n = 1'b0;
        @(negedge clk);
        counter_rst_n = 1'b1;
        @(negedge clk);
`ifdef PA_PARTIAL_TILE_EN
        run_job(20, 8, 4, 1'b0, 1'b0, -1, 100, 16, 20, 2, 1'b0);
        check_eq("partial_err", err, 1'b0);
`else
        rhs_rows = 20; rhs_cols = 8; lhs_rows = 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("tile_err", err, 1'b1);
        check_eq("tile_err_busy", busy, 1'b0);
        rdy_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.wt_rdy || bus.dat_rdy || bus.res_vld) rdy_seen++;
        end
        check_eq("tile_err_no_xfer", rdy_seen, 0);
        check_eq("tile_err_sticky", err, 1'b1);
`endif

        // lhs_rows not a multiple of LANES
        counter_rst_n = 1'b0;
        @(negedge clk);
        counter_rst_n = 1'b1;
        check_eq("rst_err_clear", err, 1'b0);
        rhs_rows = 16; rhs_cols = 8; lhs_rows = 6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("lane_err", err, 1'b1);
        check_eq("lane_err_state", state, 3'd0);
        check_eq("lane_err_done", done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
